// File: rtl/alu_cmd_sender.sv
// alu_cmd_sender: sends A, B, {0,opcode} as three UART bytes, then waits for one result byte or a timeout.
// Optional macro ALU_CMD_RETRY_EN: resend the latched command once after the first timeout.

module alu_cmd_sender #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int NBIT_OP        = 6,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [NBIT_DATA_LEN-1:0] a,
  input  logic [NBIT_DATA_LEN-1:0] b,
  input  logic [NBIT_OP-1:0]       opcode,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data,
  input  logic                     tx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data,
  input  logic                     rx_done_tick,
  output logic                     rsp_valid,
  output logic [NBIT_DATA_LEN-1:0] rsp_data,
  output logic                     rsp_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_A   = 3'd1,
    ST_WAIT_A   = 3'd2,
    ST_SEND_B   = 3'd3,
    ST_WAIT_B   = 3'd4,
    ST_SEND_OP  = 3'd5,
    ST_WAIT_OP  = 3'd6,
    ST_WAIT_RSP = 3'd7
  } state_t;

  function automatic logic [NBIT_DATA_LEN-1:0] op_to_byte(input logic [NBIT_OP-1:0] op);
    return NBIT_DATA_LEN'(op);
  endfunction

  state_t                   state_r, state_s;
  logic [TW-1:0]            timer_r, timer_s;
  logic [NBIT_DATA_LEN-1:0] b_r;
  logic [NBIT_OP-1:0]       op_r;
  logic                     cmd_ready_r, cmd_ready_s;
  logic                     tx_start_r, tx_start_s;
  logic [NBIT_DATA_LEN-1:0] tx_data_r, tx_data_s;
  logic                     rsp_valid_r, rsp_valid_s;
  logic [NBIT_DATA_LEN-1:0] rsp_data_r, rsp_data_s;
  logic                     rsp_timeout_r, rsp_timeout_s;
  logic                     accept_s;
`ifdef ALU_CMD_RETRY_EN
  logic [NBIT_DATA_LEN-1:0] a_r;
  logic                     retry_r, retry_s;
`endif

  assign accept_s = cmd_valid && cmd_ready_r;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_s       = state_r;
    timer_s       = {TW{1'b0}};
    tx_data_s     = tx_data_r;
    rsp_data_s    = rsp_data_r;
    rsp_valid_s   = 1'b0;
    rsp_timeout_s = 1'b0;
`ifdef ALU_CMD_RETRY_EN
    retry_s       = retry_r;
`endif
    case (state_r)
      ST_IDLE: begin
`ifdef ALU_CMD_RETRY_EN
        retry_s = 1'b0;
`endif
        if (accept_s) begin
          state_s   = ST_SEND_A;
          tx_data_s = a;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND_A:  state_s = ST_WAIT_A;
      ST_WAIT_A: begin
        if (tx_done_tick) begin
          state_s   = ST_SEND_B;
          tx_data_s = b_r;
        end else begin
          state_s = ST_WAIT_A;
        end
      end
      ST_SEND_B:  state_s = ST_WAIT_B;
      ST_WAIT_B: begin
        if (tx_done_tick) begin
          state_s   = ST_SEND_OP;
          tx_data_s = op_to_byte(op_r);
        end else begin
          state_s = ST_WAIT_B;
        end
      end
      ST_SEND_OP: state_s = ST_WAIT_OP;
      ST_WAIT_OP: begin
        if (tx_done_tick) begin
          state_s = ST_WAIT_RSP;
        end else begin
          state_s = ST_WAIT_OP;
        end
      end
      ST_WAIT_RSP: begin
        // A byte arriving on the expiry cycle still counts as a response.
        if (rx_done_tick) begin
          rsp_data_s  = rx_data;
          rsp_valid_s = 1'b1;
          state_s     = ST_IDLE;
        end else if (timer_r == TIMER_LAST) begin
`ifdef ALU_CMD_RETRY_EN
          if (!retry_r) begin
            retry_s   = 1'b1;
            state_s   = ST_SEND_A;
            tx_data_s = a_r;
          end else begin
            rsp_timeout_s = 1'b1;
            state_s       = ST_IDLE;
          end
`else
          rsp_timeout_s = 1'b1;
          state_s       = ST_IDLE;
`endif
        end else begin
          timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
          state_s = ST_WAIT_RSP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    tx_start_s  = (state_s == ST_SEND_A) || (state_s == ST_SEND_B) || (state_s == ST_SEND_OP);
    cmd_ready_s = (state_s == ST_IDLE);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TW{1'b0}};
      cmd_ready_r   <= 1'b1;
      tx_start_r    <= 1'b0;
      tx_data_r     <= {NBIT_DATA_LEN{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= {NBIT_DATA_LEN{1'b0}};
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      cmd_ready_r   <= cmd_ready_s;
      tx_start_r    <= tx_start_s;
      tx_data_r     <= tx_data_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_data_r    <= rsp_data_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  // Command operands captured at acceptance; input changes afterwards are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_r     <= {NBIT_DATA_LEN{1'b0}};
      op_r    <= {NBIT_OP{1'b0}};
`ifdef ALU_CMD_RETRY_EN
      a_r     <= {NBIT_DATA_LEN{1'b0}};
      retry_r <= 1'b0;
`endif
    end else begin
`ifdef ALU_CMD_RETRY_EN
      retry_r <= retry_s;
`endif
      if (accept_s) begin
        b_r  <= b;
        op_r <= opcode;
`ifdef ALU_CMD_RETRY_EN
        a_r  <= a;
`endif
      end
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Randomized self-checking bench for alu_cmd_sender: transaction-level model of the byte
// sequence, response/timeout timing, noise rejection and asynchronous reset abort.

module tb_alu_cmd_sender;

  localparam int DW = 8;
  localparam int OW = 6;
  localparam int TO = 16;
`ifdef ALU_CMD_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] a = 8'h00;
  logic [DW-1:0] b = 8'h00;
  logic [OW-1:0] opcode = 6'h00;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_done_tick = 1'b0;
  logic [DW-1:0] rx_data = 8'h00;
  logic          rx_done_tick = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;

  int            n_cmp = 0;
  int            n_mis = 0;
  logic [DW-1:0] model_rsp = 8'h00;

  always #5 clk = ~clk;

  alu_cmd_sender #(
    .NBIT_DATA_LEN (DW),
    .NBIT_OP       (OW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done_tick(tx_done_tick),
    .rx_data     (rx_data),
    .rx_done_tick(rx_done_tick),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cmd_ready"},   32'(cmd_ready),   32'd1);
    check_eq({tag, "_tx_start"},    32'(tx_start),    32'd0);
    check_eq({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check_eq({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check_eq({tag, "_rsp_data"},    32'(rsp_data),    32'd0);
    check_eq({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
  endtask

  task automatic check_busy_quiet(input string tag);
    check_eq({tag, "_tx_start"},    32'(tx_start),    32'd0);
    check_eq({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check_eq({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    check_eq({tag, "_cmd_ready"},   32'(cmd_ready),   32'd0);
  endtask

  // mode 0: respond at WAIT_RSP cycle r; 1: never respond; 2: respond at r on the retry only.
  // Called and returns at a falling edge with the DUT idle.
  task automatic run_cmd(input logic [DW-1:0] ca, input logic [DW-1:0] cb, input logic [OW-1:0] cop,
                         input int mode, input int r, input int dly, input bit noise,
                         input logic [DW-1:0] rv);
    logic [DW-1:0] exp_b [3];
    int            attempts;
    int            d;
    bit            respond;
    exp_b[0] = ca;
    exp_b[1] = cb;
    exp_b[2] = {2'b00, cop};
    attempts = (mode != 0 && RETRY) ? 2 : 1;

    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    a = ca;
    b = cb;
    opcode = cop;
    @(negedge clk);
    cmd_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    opcode = 6'($urandom);

    for (int att = 0; att < attempts; att++) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("send_tx_start", 32'(tx_start), 32'd1);
        check_eq("send_tx_data", 32'(tx_data), 32'(exp_b[i]));
        check_eq("send_cmd_ready", 32'(cmd_ready), 32'd0);
        if (noise) tx_done_tick = 1'b1;
        d = (dly > 0) ? dly : $urandom_range(1, 12);
        for (int k = 1; k <= d; k++) begin
          @(negedge clk);
          tx_done_tick = 1'b0;
          rx_done_tick = 1'b0;
          check_eq("wait_tx_start", 32'(tx_start), 32'd0);
          check_eq("wait_tx_data", 32'(tx_data), 32'(exp_b[i]));
          if (noise) begin
            rx_done_tick = 1'($urandom_range(0, 1));
            rx_data      = 8'($urandom);
            cmd_valid    = 1'($urandom_range(0, 1));
            a            = 8'($urandom);
            b            = 8'($urandom);
            opcode       = 6'($urandom);
          end
          if (k == d) tx_done_tick = 1'b1;
        end
        @(negedge clk);
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        cmd_valid    = 1'b0;
      end

      respond = (mode == 0) || (mode == 2 && att == 1);
      if (respond) begin
        for (int j = 0; j < r; j++) begin
          check_busy_quiet("rsp_wait");
          if (noise) tx_done_tick = 1'($urandom_range(0, 1));
          @(negedge clk);
          tx_done_tick = 1'b0;
        end
        check_busy_quiet("rsp_wait");
        rx_data      = rv;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
        model_rsp    = rv;
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(rsp_data), 32'(model_rsp));
        check_eq("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rsp_no_timeout", 32'(rsp_timeout), 32'd0);
      end else begin
        for (int j = 0; j < TO; j++) begin
          check_busy_quiet("to_wait");
          if (noise) tx_done_tick = 1'($urandom_range(0, 1));
          @(negedge clk);
          tx_done_tick = 1'b0;
        end
        if (att < attempts - 1) begin
          check_eq("retry_no_timeout", 32'(rsp_timeout), 32'd0);
          check_eq("retry_cmd_ready", 32'(cmd_ready), 32'd0);
        end else begin
          check_eq("rsp_timeout", 32'(rsp_timeout), 32'd1);
          check_eq("to_no_valid", 32'(rsp_valid), 32'd0);
          check_eq("to_cmd_ready", 32'(cmd_ready), 32'd1);
        end
      end
    end

    @(negedge clk);
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_rsp_data_held", 32'(rsp_data), 32'(model_rsp));
  endtask

  // Reset asserted between clock edges while waiting for byte A to finish.
  task automatic reset_abort();
    check_eq("ra_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    a = 8'hA5;
    b = 8'h5A;
    opcode = 6'h15;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("ra_tx_start", 32'(tx_start), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_rsp = 8'h00;
    check_reset_values("async_rst");
    for (int k = 0; k < 4; k++) begin
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check_eq("ra_no_tx_start", 32'(tx_start), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_done_tick = 1'($urandom_range(0, 1));
      @(negedge clk);
      tx_done_tick = 1'b0;
      check_eq("ra_after_tx_start", 32'(tx_start), 32'd0);
      check_eq("ra_after_cmd_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    int mode;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(8'h05, 8'h03, 6'h20, 0, 4, 10, 1'b0, 8'h08);
    run_cmd(8'h00, 8'h00, 6'h00, 0, 0, 1, 1'b0, 8'h00);
    run_cmd(8'hC3, 8'h7E, 6'h3F, 1, 0, 3, 1'b0, 8'h00);
    run_cmd(8'h12, 8'h34, 6'h01, 0, TO - 1, 2, 1'b0, 8'h9C);
    run_cmd(8'h11, 8'h22, 6'h2A, 0, 2, 0, 1'b1, 8'h5B);
    run_cmd(8'hFF, 8'h80, 6'h10, 2, 5, 0, 1'b1, 8'hE7);
    reset_abort();

    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 2);
      run_cmd(8'($urandom), 8'($urandom), 6'($urandom), mode, $urandom_range(0, TO - 1),
              0, 1'($urandom_range(0, 1)), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    n_mis++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog expired");
  end

endmodule
